// File: rtl/spi_tx_master.sv
// Mode-0 SPI initiator: MSB-first word on cs/sclk/mosi, sclk half-period = CLK_DIV sys_clk cycles.
// Latency: cs falls one cycle after an accepted start; done pulses 2*CLK_DIV*(REG_WIDTH+1)+1 cycles after start.
// Backpressure: start is ignored while busy; with SPI_TX_BURST_EN a start in the last HOLD cycle chains the next word.
module spi_tx_master #(
    parameter int REG_WIDTH = 8,
    parameter int CLK_DIV   = 4
) (
    input  logic                 sys_clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [REG_WIDTH-1:0] data_in,
    output logic                 busy,
    output logic                 done,
    output logic                 cs,
    output logic                 sclk,
    output logic                 mosi
);

    localparam int CNT_W = $clog2(REG_WIDTH + 1);
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_RELOAD = DIV_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] LAST_EDGE  = CNT_W'(REG_WIDTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_SHIFT_HI,
        S_SHIFT_LO,
        S_HOLD
    } state_t;

    state_t                state_q, state_d;
    logic [DIV_W-1:0]      div_q, div_d;
    logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic [REG_WIDTH-1:0]  shreg_q, shreg_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  cs_q, cs_d;
    logic                  sclk_q, sclk_d;
    logic                  mosi_q, mosi_d;
    logic                  div_zero;

    assign div_zero = (div_q == '0);

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shreg_d   = shreg_q;
        done_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d   = S_SETUP;
                    shreg_d   = data_in;
                    bit_cnt_d = '0;
                end
            end
            S_SETUP: begin
                if (div_zero) begin
                    state_d   = S_SHIFT_HI;
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                end
            end
            S_SHIFT_HI: begin
                if (div_zero) begin
                    state_d = S_SHIFT_LO;
                    // After the final rising edge there is no next bit; mosi simply holds.
                    if (bit_cnt_q != LAST_EDGE) begin
                        shreg_d = {shreg_q[REG_WIDTH-2:0], 1'b0};
                    end
                end
            end
            S_SHIFT_LO: begin
                if (div_zero) begin
                    if (bit_cnt_q == LAST_EDGE) begin
                        state_d = S_HOLD;
                    end else begin
                        state_d   = S_SHIFT_HI;
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end
                end
            end
            S_HOLD: begin
                if (div_zero) begin
                    done_d = 1'b1;
`ifdef SPI_TX_BURST_EN
                    if (start) begin
                        state_d   = S_SETUP;
                        shreg_d   = data_in;
                        bit_cnt_d = '0;
                    end else begin
                        state_d = S_IDLE;
                    end
`else
                    state_d = S_IDLE;
`endif
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Burst chaining leaves HOLD for SETUP, which also counts as a state change here.
        if (state_d != state_q || (state_q == S_HOLD && div_zero)) begin
            div_d = DIV_RELOAD;
        end else if (!div_zero) begin
            div_d = div_q - DIV_W'(1);
        end else begin
            div_d = div_q;
        end

        busy_d = (state_d != S_IDLE);
        cs_d   = (state_d == S_IDLE);
        sclk_d = (state_d == S_SHIFT_HI);
        mosi_d = (state_d == S_IDLE) ? 1'b1 : shreg_d[REG_WIDTH-1];
    end

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            div_q     <= '0;
            bit_cnt_q <= '0;
            shreg_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            cs_q      <= 1'b1;
            sclk_q    <= 1'b0;
            mosi_q    <= 1'b1;
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            bit_cnt_q <= bit_cnt_d;
            shreg_q   <= shreg_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            cs_q      <= cs_d;
            sclk_q    <= sclk_d;
            mosi_q    <= mosi_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign cs   = cs_q;
    assign sclk = sclk_q;
    assign mosi = mosi_q;

endmodule

// File: tb/tb_spi_tx_master.sv
// Bench for spi_tx_master: one instance at CLK_DIV=4 and one at CLK_DIV=1, checked cycle by cycle
// against the frame timing formulas (cs window, sclk edge times, mosi bit windows, done cycle).
module tb_spi_tx_master;

    localparam int W = 8;

    logic sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    logic         rst;
    logic         start0, start1;
    logic [W-1:0] din0, din1;
    logic         busy0, done0, cs0, sclk0, mosi0;
    logic         busy1, done1, cs1, sclk1, mosi1;

    spi_tx_master #(.REG_WIDTH(W), .CLK_DIV(4)) dut (
        .sys_clk(sys_clk), .rst(rst), .start(start0), .data_in(din0),
        .busy(busy0), .done(done0), .cs(cs0), .sclk(sclk0), .mosi(mosi0)
    );

    spi_tx_master #(.REG_WIDTH(W), .CLK_DIV(1)) dut_h1 (
        .sys_clk(sys_clk), .rst(rst), .start(start1), .data_in(din1),
        .busy(busy1), .done(done1), .cs(cs1), .sclk(sclk1), .mosi(mosi1)
    );

    int errors = 0;
    int checks = 0;

    logic msel;
    logic m_busy, m_done, m_cs, m_sclk, m_mosi;
    always_comb begin
        m_busy = msel ? busy1 : busy0;
        m_done = msel ? done1 : done0;
        m_cs   = msel ? cs1   : cs0;
        m_sclk = msel ? sclk1 : sclk0;
        m_mosi = msel ? mosi1 : mosi0;
    end

    task automatic set_start(input logic sel, input logic s);
        if (sel) start1 = s; else start0 = s;
    endtask

    task automatic set_data(input logic sel, input logic [W-1:0] d);
        if (sel) din1 = d; else din0 = d;
    endtask

    // Pulse start for one cycle; afterwards data_in is scrambled to prove it was captured.
    task automatic launch(input logic sel, input logic [W-1:0] d);
        msel = sel;
        @(negedge sys_clk);
        set_start(sel, 1'b1);
        set_data(sel, d);
        @(negedge sys_clk);
        set_start(sel, 1'b0);
        set_data(sel, ~d);
    endtask

    // Checks one frame, starting at the negedge of cycle N+1 (t=1).
    task automatic frame_check(input logic sel, input logic [W-1:0] data, input bit chained,
                               input int poke_t, input logic [W-1:0] poke_d, input int rst_t,
                               input bit burst_next, input logic [W-1:0] next_d);
        int h;
        int tl;
        int edges;
        logic [W-1:0] word;
        logic prev_sclk;
        h = sel ? 1 : 4;
        tl = 2 * h * (W + 1);
        edges = 0;
        word = '0;
        prev_sclk = 1'b0;
        msel = sel;
        for (int t = 1; t <= tl + 1; t++) begin
            logic e_sclk, e_busy, e_done, e_cs;
            int kb;
            if (rst_t > 0 && t == rst_t + 1) begin
                checks++;
                if ({m_cs, m_sclk, m_mosi, m_busy, m_done} !== 5'b10100) begin
                    errors++;
                    $display("FAIL rst_mid_values t=%0d got cs,sclk,mosi,busy,done=%b exp=10100",
                             t, {m_cs, m_sclk, m_mosi, m_busy, m_done});
                end
                rst = 1'b0;
                for (int i = 0; i < tl; i++) begin
                    @(negedge sys_clk);
                    checks++;
                    if (m_done !== 1'b0 || m_cs !== 1'b1) begin
                        errors++;
                        $display("FAIL rst_mid_no_done i=%0d got done=%b cs=%b exp done=0 cs=1", i, m_done, m_cs);
                    end
                end
                return;
            end
            e_sclk = 1'b0;
            kb = -1;
            for (int k = 0; k < W; k++) begin
                int te;
                te = 1 + h + 2 * h * k;
                if (t >= te && t < te + h) e_sclk = 1'b1;
                if (t >= te - h && t < te + h) kb = W - 1 - k;
            end
            e_done = (t == tl + 1) || (chained && t == 1);
            e_busy = (t <= tl) || burst_next;
            e_cs   = ~e_busy;
            checks++;
            if ({m_cs, m_sclk, m_busy, m_done} !== {e_cs, e_sclk, e_busy, e_done}) begin
                errors++;
                $display("FAIL frame_ctl sel=%0d t=%0d got cs,sclk,busy,done=%b exp=%b",
                         sel, t, {m_cs, m_sclk, m_busy, m_done}, {e_cs, e_sclk, e_busy, e_done});
            end
            if (t == tl + 1) begin
                logic e_m;
                e_m = burst_next ? next_d[W-1] : 1'b1;
                checks++;
                if (m_mosi !== e_m) begin
                    errors++;
                    $display("FAIL frame_end_mosi sel=%0d got=%b exp=%b", sel, m_mosi, e_m);
                end
            end else if (kb >= 0) begin
                checks++;
                if (m_mosi !== data[kb]) begin
                    errors++;
                    $display("FAIL mosi_window sel=%0d t=%0d got=%b exp=%b", sel, t, m_mosi, data[kb]);
                end
            end
            if (m_sclk && !prev_sclk) begin
                edges++;
                word = {word[W-2:0], m_mosi};
            end
            prev_sclk = m_sclk;
            if (t == poke_t) begin
                set_start(sel, 1'b1);
                set_data(sel, poke_d);
            end
            if (t == poke_t + 1) set_start(sel, 1'b0);
            if (burst_next && t == tl) begin
                set_start(sel, 1'b1);
                set_data(sel, next_d);
            end
            if (burst_next && t == tl + 1) set_start(sel, 1'b0);
            if (rst_t > 0 && t == rst_t) rst = 1'b1;
            if (t <= tl) @(negedge sys_clk);
        end
        checks++;
        if (edges != W || word !== data) begin
            errors++;
            $display("FAIL frame_word sel=%0d got edges=%0d word=%h exp edges=%0d word=%h", sel, edges, word, W, data);
        end
    endtask

    // Idle-line checks for n cycles after a frame.
    task automatic idle_check(input logic sel, input int n, input string name);
        msel = sel;
        for (int i = 0; i < n; i++) begin
            @(negedge sys_clk);
            checks++;
            if ({m_cs, m_sclk, m_busy, m_done} !== 4'b1000) begin
                errors++;
                $display("FAIL %s i=%0d got cs,sclk,busy,done=%b exp=1000", name, i, {m_cs, m_sclk, m_busy, m_done});
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start0 = 1'b1;
        start1 = 1'b1;
        din0 = 8'hA5;
        din1 = 8'h5A;
        repeat (3) @(negedge sys_clk);
        start0 = 1'b0;
        start1 = 1'b0;
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            checks++;
            if ({cs0, sclk0, mosi0, busy0, done0, cs1, sclk1, mosi1, busy1, done1} !== 10'b10100_10100) begin
                errors++;
                $display("FAIL reset_idle i=%0d got=%b exp=1010010100", i,
                         {cs0, sclk0, mosi0, busy0, done0, cs1, sclk1, mosi1, busy1, done1});
            end
            @(negedge sys_clk);
        end
    endtask

    task automatic test_pattern_a5();
        launch(1'b0, 8'hA5);
        frame_check(1'b0, 8'hA5, 1'b0, -5, '0, 0, 1'b0, '0);
        idle_check(1'b0, 3, "a5_after_done");
    endtask

    task automatic test_div1_3c();
        launch(1'b1, 8'h3C);
        frame_check(1'b1, 8'h3C, 1'b0, -5, '0, 0, 1'b0, '0);
        idle_check(1'b1, 3, "div1_after_done");
    endtask

    task automatic test_random();
        for (int i = 0; i < 6; i++) begin
            logic sel;
            logic [W-1:0] d;
            sel = 1'(i % 2);
            d = W'($urandom);
            launch(sel, d);
            frame_check(sel, d, 1'b0, -5, '0, 0, 1'b0, '0);
        end
        idle_check(1'b1, 2, "random_after_done");
    endtask

    task automatic test_ignore_start();
        logic [W-1:0] d;
        d = W'($urandom_range(0, 254));
        launch(1'b0, d);
        frame_check(1'b0, d, 1'b0, 20, 8'hFF, 0, 1'b0, '0);
        idle_check(1'b0, 80, "ignore_no_second_frame");
    endtask

    task automatic test_reset_mid();
        logic [W-1:0] d;
        d = W'($urandom);
        launch(1'b0, d);
        frame_check(1'b0, d, 1'b0, -5, '0, 30, 1'b0, '0);
        launch(1'b0, 8'h81);
        frame_check(1'b0, 8'h81, 1'b0, -5, '0, 0, 1'b0, '0);
        idle_check(1'b0, 2, "after_rst_frame");
    endtask

`ifdef SPI_TX_BURST_EN
    task automatic test_back_to_back();
        launch(1'b0, 8'h12);
        frame_check(1'b0, 8'h12, 1'b0, -5, '0, 0, 1'b1, 8'h34);
        frame_check(1'b0, 8'h34, 1'b1, -5, '0, 0, 1'b0, '0);
        idle_check(1'b0, 3, "burst_after_done");
    endtask
`else
    task automatic test_back_to_back();
        launch(1'b0, 8'h12);
        frame_check(1'b0, 8'h12, 1'b0, 72, 8'h34, 0, 1'b0, '0);
        idle_check(1'b0, 80, "hold_start_ignored");
    endtask
`endif

    initial begin
        rst = 1'b1;
        start0 = 1'b0;
        start1 = 1'b0;
        din0 = '0;
        din1 = '0;
        msel = 1'b0;
        test_reset();
        test_pattern_a5();
        test_div1_3c();
        test_random();
        test_ignore_start();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/spi_tx_master.md
# spi_tx_master

SPI transmitter (initiator side) that serialises a parallel word onto `cs`/`sclk`/`mosi` for the LED-runner SPI receiver and any other mode-0 SPI target in the design. The bit clock is derived from `sys_clk` by a programmable divider. Transfers are MSB first with active-low chip select. The host side is a single-cycle `start` strobe with `busy`/`done` status.

## Interface
Parameters:
- `REG_WIDTH`, 8: bits per transfer; must be ≥2.
- `CLK_DIV`, 4: `sys_clk` cycles per `sclk` half-period (H); must be ≥1.

Ports:
- `sys_clk`  input  1  system clock; all logic on its rising edge.
- `rst`  input  1  reset; synchronous, active-high.
- `start`  input  1  transfer request, sampled when `busy`=0.
- `data_in`  input  REG_WIDTH  word to send, captured on accepted `start`.
- `busy`  output  1  high while a transfer is in progress.
- `done`  output  1  one-cycle pulse at end of each word.
- `cs`  output  1  chip select, active low.
- `sclk`  output  1  SPI clock, idle low (CPOL=0).
- `mosi`  output  1  serial data, valid around `sclk` rising edges (CPHA=0).

## Operation
- All outputs are registered. Reset values: `cs`=1, `sclk`=0, `mosi`=1, `busy`=0, `done`=0.
- States:
  - IDLE: outputs at reset values, except that `done` may be high for its pulse cycle.
  - SETUP: `cs`=0, `mosi`=current MSB, `sclk`=0; lasts H cycles.
  - SHIFT_HI: `sclk`=1 for H cycles.
  - SHIFT_LO: `sclk`=0 for H cycles; `mosi` advances to the next bit on entry.
  - HOLD: `cs`=0, `sclk`=0 for H cycles after the last falling edge.
- Transitions:
  - IDLE→SETUP on `start`=1.
  - SETUP→SHIFT_HI.
  - SHIFT_HI→SHIFT_LO.
  - SHIFT_LO→SHIFT_HI while bits remain, else →HOLD.
  - HOLD→IDLE.
- Shift register is loaded from `data_in` on acceptance. Changes to `data_in` after acceptance are ignored.
- Bit counter is ceil(log2(REG_WIDTH+1)) bits wide and counts rising edges. Exactly REG_WIDTH rising edges are produced per word.
- Divider counter is ceil(log2(CLK_DIV)) bits (minimum 1) and reloads on every state change.
- `start` while `busy`=1 is ignored (but see Configuration).
- `rst` mid-transfer: the next cycle shows reset values on all outputs. The transfer is abandoned and no `done` pulse is generated.
- `start` and `rst` in the same cycle: `rst` wins.

## Timing
- Accepted `start` in cycle N. In cycle N+1: `cs`=0, `busy`=1, `mosi`=`data_in`[REG_WIDTH-1].
- Rising edge k (k=0..REG_WIDTH-1) of `sclk` occurs at cycle N+1+H+2Hk. Bit REG_WIDTH-1-k is stable on `mosi` from H cycles before that edge until H cycles after it.
- `cs` is low for exactly 2H·(REG_WIDTH+1) cycles. For the defaults this is 72 cycles: N+1..N+72.
- In cycle N+1+2H·(REG_WIDTH+1): `cs`=1, `mosi`=1, `busy`=0, `done`=1 for one cycle.
- A new `start` is accepted in the `done` cycle, so the minimum `cs`-high gap between words is 1 cycle.
- H=1 gives `sclk` = `sys_clk`/2.

## Configuration
- `SPI_TX_BURST_EN` defined:
  - `start`=1 in the last HOLD cycle captures `data_in` and goes directly to SETUP.
  - The next cycle shows `done`=1 with `cs` still 0, `busy` still 1, and `mosi`=new MSB.
  - Words are therefore sent back-to-back inside one `cs` frame, with the final word followed by a normal return to IDLE.
- `SPI_TX_BURST_EN` undefined:
  - `start` during any busy state, including HOLD, is ignored.
  - Every word gets its own `cs` frame.

## Test plan
- Reset, then idle 10 cycles → `cs`=1, `sclk`=0, `mosi`=1, `busy`=0, `done`=0 throughout.
- Defaults, `data_in`=8'hA5, `start` pulse at cycle 0:
  - Sampling `mosi` on `sclk` rising edges yields 1,0,1,0,0,1,0,1.
  - Exactly 8 rising edges; `cs` low for cycles 1..72; `done`=1 at cycle 73 only.
- CLK_DIV=1, `data_in`=8'h3C → `sclk` toggles every cycle; `cs` low 18 cycles; captured byte 8'h3C.
- During a transfer, change `data_in` to 8'hFF and pulse `start` at cycle 20 → transmitted byte unchanged. Without `SPI_TX_BURST_EN`, no second frame follows.
- Assert `rst` at cycle 30 of a transfer → cycle 31 shows reset values and no `done` pulse. A fresh `start` of 8'h81 then transmits correctly.
- With `SPI_TX_BURST_EN`, send 8'h12 then 8'h34 with the second `start` in the last HOLD cycle → one `cs` frame of 16 rising edges carrying 0x12,0x34. Two `done` pulses, 72 cycles apart.
